mul_seq: RTL and testbench

Sequential 16x16 unsigned shift-and-add multiplier for the ALU. It time-shares one instance of the team's 16-bit carry-lookahead adder across 16 iterations and produces a 32-bit product. It sits beside the single-cycle ALU datapath, and the control unit stalls issue on `busy`. It trades the area of an array multiplier for a fixed 18-cycle occupancy.

---
 rtl/mul_seq_pkg.sv | 14 +
 rtl/cla.sv | 58 +++++
 rtl/mul_seq.sv | 110 +++++++++++
 tb/tb_mul_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared ALU constants and types for the sequential multiplier and its adder.
package mul_seq_pkg;

    localparam int MUL_W    = 16;
    localparam int MUL_ITER = 16;
    localparam int CNT_W    = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/cla.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a
// second lookahead level over the group generate/propagate terms.
module cla
    import mul_seq_pkg::*;
(
    input  logic [MUL_W-1:0] A,
    input  logic [MUL_W-1:0] B,
    input  logic             C_in,
    output logic [MUL_W-1:0] S,
    output logic             C_out
);

    logic [MUL_W-1:0] g;
    logic [MUL_W-1:0] p;
    logic [MUL_W-1:0] c;
    logic [3:0]       gg;
    logic [3:0]       pg;
    logic [4:0]       gc;

    assign g = A & B;
    assign p = A ^ B;

    always_comb begin
        gg = '0;
        pg = '0;
        gc = '0;
        c  = '0;
        for (int i = 0; i < 4; i++) begin
            gg[i] = g[4*i+3]
                  | (p[4*i+3] & g[4*i+2])
                  | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                  | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
            pg[i] = &p[4*i +: 4];
        end
        // Second-level lookahead: every group carry-in comes straight from C_in.
        gc[0] = C_in;
        gc[1] = gg[0] | (pg[0] & C_in);
        gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & C_in);
        gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
              | (pg[2] & pg[1] & pg[0] & C_in);
        gc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
              | (pg[3] & pg[2] & pg[1] & gg[0])
              | (pg[3] & pg[2] & pg[1] & pg[0] & C_in);
        for (int i = 0; i < 4; i++) begin
            c[4*i]   = gc[i];
            c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
            c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i])
                     | (p[4*i+1] & p[4*i] & gc[i]);
            c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1])
                     | (p[4*i+2] & p[4*i+1] & g[4*i])
                     | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
        end
    end

    assign S     = p ^ c;
    assign C_out = gc[4];

endmodule

// File: rtl/mul_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier sharing one CLA across
// 16 iterations; fixed 17-cycle busy window followed by one idle cycle.
module mul_seq
    import mul_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MUL_W-1:0]     a,
    input  logic [MUL_W-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*MUL_W-1:0]   product
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_ITER - 1);

    mul_state_e         state_q, state_d;
    logic [MUL_W-1:0]   mcand_q, mcand_d;
    logic [MUL_W-1:0]   hi_q, hi_d;
    logic [MUL_W-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*MUL_W-1:0] product_q, product_d;

    logic [MUL_W-1:0]   add_b;
    logic [MUL_W-1:0]   sum;
    logic               carry;
    logic [2*MUL_W-1:0] shifted;

    assign add_b = lo_q[0] ? mcand_q : '0;

    cla u_cla (
        .A     (hi_q),
        .B     (add_b),
        .C_in  (1'b0),
        .S     (sum),
        .C_out (carry)
    );

    // The adder carry becomes the MSB of the shifted partial product.
    assign shifted = {carry, sum, lo_q[MUL_W-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == LAST_ITER) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    always_comb begin
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = a;
                    lo_d    = b;
                    hi_d    = '0;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                {hi_d, lo_d} = shifted;
                cnt_d        = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    product_d = shifted;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: expected products queued at issue, compared when done pulses.
module tb_mul_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    logic [31:0] expQ[$];

    mul_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle start pulse; returns in the first CALC cycle.
    task automatic applyStimulus(input logic [15:0] opA, input logic [15:0] opB);
        @(negedge clk);
        start = 1'b1;
        a     = opA;
        b     = opB;
        expQ.push_back(32'(opA) * 32'(opB));
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Called in cycle k+1; expects done in cycle k+17, then idle.
    task automatic waitDone(input string tag, output int doneCycle);
        int n;
        logic [31:0] exp;
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        doneCycle = cycle;
        checkOutput({tag, "_latency"}, 32'(n), 32'd17);
        exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hDEADBEEF;
        checkOutput({tag, "_product"}, product, exp);
        checkOutput({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput({tag, "_busy_idle"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done_idle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int d1;
        int d2;
        int doneCount;
        logic [31:0] seen;
        logic [15:0] ra;
        logic [15:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_product", product, 32'd0);
        rst = 1'b0;

        applyStimulus(16'd3, 16'd5);
        checkOutput("fifteen_expected", expQ[0], 32'h0000000F);
        waitDone("3x5", d1);

        applyStimulus(16'hFFFF, 16'hFFFF);
        checkOutput("max_expected", expQ[0], 32'hFFFE0001);
        waitDone("max", d1);

        // Back-to-back: second start is sampled at the end of the idle cycle.
        applyStimulus(16'h8000, 16'h0002);
        waitDone("b2b_first", d1);
        start = 1'b1;
        a     = 16'h0000;
        b     = 16'h1234;
        expQ.push_back(32'h00000000);
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_busy", 32'(busy), 32'd1);
        waitDone("b2b_second", d2);
        checkOutput("b2b_spacing", 32'(d2 - d1), 32'd18);

        // Start held high throughout: only the idle cycle accepts the second request.
        @(negedge clk);
        start = 1'b1;
        a     = 16'd7;
        b     = 16'd9;
        @(negedge clk);
        a         = 16'd1;
        b         = 16'd1;
        doneCount = 0;
        seen      = '0;
        for (int n = 1; n <= 17; n++) begin
            if (done === 1'b1) begin
                doneCount++;
                seen = product;
            end
            if (n < 17) @(negedge clk);
        end
        checkOutput("held_done_count", 32'(doneCount), 32'd1);
        checkOutput("held_product", seen, 32'h0000003F);
        @(negedge clk);
        checkOutput("held_idle_busy", 32'(busy), 32'd0);
        expQ.push_back(32'd1);
        @(negedge clk);
        start = 1'b0;
        checkOutput("held_second_busy", 32'(busy), 32'd1);
        waitDone("held_second", d1);

        // Reset mid-operation aborts with no done pulse.
        applyStimulus(16'h1234, 16'h5678);
        void'(expQ.pop_back());
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_product", product, 32'd0);
        doneCount = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) doneCount++;
        end
        checkOutput("abort_no_done", 32'(doneCount), 32'd0);
        applyStimulus(16'd2, 16'd3);
        waitDone("2x3", d1);

        // Reset and start together: reset wins.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        a     = 16'd5;
        b     = 16'd5;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("rst_start_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("rst_start_busy_later", 32'(busy), 32'd0);
        checkOutput("rst_start_done", 32'(done), 32'd0);

        for (int i = 0; i < 3; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            applyStimulus(ra, rb);
            waitDone("random", d1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
